// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NUM_SRC 1-cycle-latency FIFOs onto one valid/ready stream,
// with an optional per-source burst allowance before priority rotates.
module fifo_rr_drain #(
  parameter  int NUM_SRC = 4,
  parameter  int DWIDTH  = 8,
  parameter  int BURST   = 1,
  localparam int SW      = $clog2(NUM_SRC),
  localparam int CW      = $clog2(BURST + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_SRC-1:0]               i_src_empty,
  input  logic [NUM_SRC-1:0]               i_src_mask,
  output logic [NUM_SRC-1:0]               o_src_pop,
  input  logic [NUM_SRC-1:0][DWIDTH-1:0]   i_src_rdata,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DWIDTH-1:0]                o_data,
  output logic [SW-1:0]                    o_src
);

  localparam logic [SW-1:0] LAST = SW'(NUM_SRC - 1);

  logic [SW-1:0]      ptr, grant, scan;
  logic [CW-1:0]      cnt, newcnt;
  logic [NUM_SRC-1:0] elig;
  logic               found, can_issue;

  assign elig      = i_src_mask & ~i_src_empty;
  assign can_issue = !o_valid || i_ready;

  // Scan from the priority head with an explicit wrap so non-power-of-2 counts work.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && elig[scan]) begin
        grant = scan;
        found = 1'b1;
      end
      scan = (scan == LAST) ? '0 : scan + SW'(1);
    end
  end

  always_comb begin
    o_src_pop = '0;
    if (can_issue && found && !i_rst) o_src_pop[grant] = 1'b1;
  end

  assign newcnt = ((grant == ptr) ? cnt : '0) + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_src   <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else if (|o_src_pop) begin
      o_valid <= 1'b1;
      o_src   <= grant;
      if (newcnt == CW'(BURST)) begin
        ptr <= (grant == LAST) ? '0 : grant + SW'(1);
        cnt <= '0;
      end else begin
        ptr <= grant;
        cnt <= newcnt;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // The source FIFO holds its read data until popped again, so no data register here.
  assign o_data = o_valid ? i_src_rdata[o_src] : '0;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: queue-backed FIFO models, a cycle-level reference
// arbiter, per-source data scoreboard, and scenario sequence checks.
module tb_fifo_rr_drain;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst   [2];
  logic [N-1:0]       empty [2];
  logic [N-1:0]       mask  [2];
  logic [N-1:0]       pop   [2];
  logic [N-1:0]       pop_s [2];
  logic [N-1:0][DW-1:0] rdata [2];
  logic               valid [2];
  logic               ready [2];
  logic [DW-1:0]      data  [2];
  logic [1:0]         src   [2];

  fifo_rr_drain #(.NUM_SRC(N), .DWIDTH(DW), .BURST(1)) dut (
    .i_clk(clk), .i_rst(rst[0]), .i_src_empty(empty[0]), .i_src_mask(mask[0]),
    .o_src_pop(pop[0]), .i_src_rdata(rdata[0]), .o_valid(valid[0]),
    .i_ready(ready[0]), .o_data(data[0]), .o_src(src[0]));

  fifo_rr_drain #(.NUM_SRC(N), .DWIDTH(DW), .BURST(3)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_src_empty(empty[1]), .i_src_mask(mask[1]),
    .o_src_pop(pop[1]), .i_src_rdata(rdata[1]), .o_valid(valid[1]),
    .i_ready(ready[1]), .o_data(data[1]), .o_src(src[1]));

  // Source FIFO contents and the expected per-source output order
  logic [DW-1:0] q   [2][N][$];
  logic [DW-1:0] exq [2][N][$];

  // Behavioural FIFOs: 1-cycle read latency, rdata held while not popped
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < N; k++) begin
        if (pop_s[u][k] && q[u][k].size() != 0) rdata[u][k] <= q[u][k].pop_front();
        empty[u][k] <= (q[u][k].size() == 0);
      end
  end

  int nrun = 0, nfail = 0;
  int bur [2] = '{1, 3};
  int mptr[2], mcnt[2], msrc[2];
  bit mv  [2];
  logic [DW-1:0] mdata[2];
  int log_src[$];

  task automatic load(input int u, input int k, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      q[u][k].push_back(d);
      exq[u][k].push_back(d);
    end
  endtask

  // One clock cycle: drive inputs, check outputs and pop against the model, advance.
  task automatic step(input int u, input bit rdy, input logic [N-1:0] msk, input bit r);
    int g, nc, k;
    logic [N-1:0] epop;
    logic [DW-1:0] e;
    ready[u] = rdy; mask[u] = msk; rst[u] = r;
    #1;
    nrun++;
    if (valid[u] !== mv[u]) begin nfail++; $display("FAIL valid u%0d: got %b want %b", u, valid[u], mv[u]); end
    nrun++;
    if (src[u] !== 2'(msrc[u])) begin nfail++; $display("FAIL src u%0d: got %0d want %0d", u, src[u], msrc[u]); end
    nrun++;
    if (data[u] !== (mv[u] ? mdata[u] : 8'h00)) begin nfail++; $display("FAIL data u%0d: got %h want %h", u, data[u], mv[u] ? mdata[u] : 8'h00); end
    g = -1;
    if (!r && (!mv[u] || rdy))
      for (int i = 0; i < N; i++) begin
        k = (mptr[u] + i) % N;
        if (g < 0 && msk[k] && !empty[u][k]) g = k;
      end
    epop = (g >= 0) ? (N'(1) << g) : '0;
    nrun++;
    if (pop[u] !== epop) begin nfail++; $display("FAIL pop u%0d: got %b want %b", u, pop[u], epop); end
    if (!r && mv[u] && rdy) begin
      log_src.push_back(msrc[u]);
      e = (exq[u][msrc[u]].size() != 0) ? exq[u][msrc[u]].pop_front() : 8'hxx;
      nrun++;
      if (data[u] !== e) begin nfail++; $display("FAIL order u%0d src%0d: got %h want %h", u, msrc[u], data[u], e); end
    end
    if (r) begin
      mv[u] = 0; msrc[u] = 0; mptr[u] = 0; mcnt[u] = 0;
    end else if (g >= 0) begin
      mdata[u] = q[u][g][0];
      mv[u] = 1; msrc[u] = g;
      nc = ((g == mptr[u]) ? mcnt[u] : 0) + 1;
      if (nc == bur[u]) begin mptr[u] = (g + 1) % N; mcnt[u] = 0; end
      else begin mptr[u] = g; mcnt[u] = nc; end
    end else if (mv[u] && rdy) begin
      mv[u] = 0;
    end
    pop_s[0] = pop[0];
    pop_s[1] = pop[1];
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) load(0, k, 3);
    for (int i = 0; i < 2; i++) begin
      step(0, 1'b1, '1, 1'b1);
      nrun++;
      if (valid[0] !== 1'b0 || src[0] !== 2'd0) begin nfail++; $display("FAIL reset_state: got v%b s%0d want v0 s0", valid[0], src[0]); end
      nrun++;
      if (pop[0] !== 4'b0) begin nfail++; $display("FAIL reset_pop: got %b want 0000", pop[0]); end
    end
    step(0, 1'b1, '1, 1'b0);
    nrun++;
    if (pop_s[0] !== 4'b0001) begin nfail++; $display("FAIL first_pop: got %b want 0001", pop_s[0]); end
  endtask

  task automatic test_round_robin();
    int vc = 0;
    bit broken = 0;
    log_src.delete();
    for (int i = 0; i < 13; i++) begin
      if (valid[0] && !broken) vc++; else broken = 1;
      step(0, 1'b1, '1, 1'b0);
    end
    nrun++;
    if (vc != 12) begin nfail++; $display("FAIL rr_valid_run: got %0d want 12", vc); end
    nrun++;
    if (log_src.size() != 12) begin nfail++; $display("FAIL rr_count: got %0d want 12", log_src.size()); end
    for (int i = 0; i < 12 && i < log_src.size(); i++) begin
      nrun++;
      if (log_src[i] != i % 4) begin nfail++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, log_src[i], i % 4); end
    end
  endtask

  task automatic test_skip();
    int ex[9] = '{1, 1, 1, 3, 1, 3, 1, 3, 1};
    log_src.delete();
    load(0, 1, 6);
    load(0, 3, 3);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 4'b0111, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 4'b1111, 1'b0);
    nrun++;
    if (log_src.size() != 9) begin nfail++; $display("FAIL skip_count: got %0d want 9", log_src.size()); end
    for (int i = 0; i < 9 && i < log_src.size(); i++) begin
      nrun++;
      if (log_src[i] != ex[i]) begin nfail++; $display("FAIL skip_seq[%0d]: got %0d want %0d", i, log_src[i], ex[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] s0;
    logic [DW-1:0] d0;
    log_src.delete();
    for (int k = 0; k < N; k++) load(0, k, 4);
    for (int i = 0; i < 4; i++) step(0, 1'b1, '1, 1'b0);
    s0 = src[0]; d0 = data[0];
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, '1, 1'b0);
      nrun++;
      if (pop_s[0] !== 4'b0) begin nfail++; $display("FAIL bp_pop: got %b want 0000", pop_s[0]); end
      nrun++;
      if (src[0] !== s0 || data[0] !== d0) begin nfail++; $display("FAIL bp_hold: got %0d/%h want %0d/%h", src[0], data[0], s0, d0); end
    end
    for (int i = 0; i < 20; i++) step(0, 1'b1, '1, 1'b0);
    nrun++;
    if (log_src.size() != 16) begin nfail++; $display("FAIL bp_count: got %0d want 16", log_src.size()); end
    for (int k = 0; k < N; k++) begin
      nrun++;
      if (exq[0][k].size() != 0) begin nfail++; $display("FAIL bp_lost src%0d: got %0d left want 0", k, exq[0][k].size()); end
    end
  endtask

  task automatic test_burst();
    int ex[10] = '{0, 0, 0, 2, 2, 2, 0, 0, 2, 2};
    log_src.delete();
    load(1, 0, 5);
    load(1, 2, 5);
    for (int i = 0; i < 16; i++) step(1, 1'b1, '1, 1'b0);
    nrun++;
    if (log_src.size() != 10) begin nfail++; $display("FAIL burst_count: got %0d want 10", log_src.size()); end
    for (int i = 0; i < 10 && i < log_src.size(); i++) begin
      nrun++;
      if (log_src[i] != ex[i]) begin nfail++; $display("FAIL burst_seq[%0d]: got %0d want %0d", i, log_src[i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N; k++) load(0, k, 3);
    for (int i = 0; i < 3; i++) step(0, 1'b1, '1, 1'b0);
    step(0, 1'b0, '1, 1'b0);
    nrun++;
    if (valid[0] !== 1'b1) begin nfail++; $display("FAIL rm_inflight: got %b want 1", valid[0]); end
    for (int k = 0; k < N; k++) begin q[0][k].delete(); exq[0][k].delete(); end
    step(0, 1'b0, '1, 1'b1);
    nrun++;
    if (pop_s[0] !== 4'b0) begin nfail++; $display("FAIL rm_pop: got %b want 0000", pop_s[0]); end
    nrun++;
    if (valid[0] !== 1'b0 || src[0] !== 2'd0) begin nfail++; $display("FAIL rm_state: got v%b s%0d want v0 s0", valid[0], src[0]); end
    for (int k = 0; k < N; k++) load(0, k, 2);
    step(0, 1'b1, '1, 1'b0);
    step(0, 1'b1, '1, 1'b0);
    nrun++;
    if (pop_s[0] !== 4'b0001) begin nfail++; $display("FAIL rm_ptr: got %b want 0001", pop_s[0]); end
    for (int i = 0; i < 12; i++) step(0, 1'b1, '1, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] msk;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) load(0, $urandom_range(0, N - 1), $urandom_range(1, 2));
      msk = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      step(0, $urandom_range(0, 3) != 0, msk, 1'b0);
    end
    for (int i = 0; i < 400; i++) step(0, 1'b1, '1, 1'b0);
    for (int k = 0; k < N; k++) begin
      nrun++;
      if (exq[0][k].size() != 0) begin nfail++; $display("FAIL rand_drain src%0d: got %0d left want 0", k, exq[0][k].size()); end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; ready[u] = 1'b1; mask[u] = '0; pop_s[u] = '0;
      mv[u] = 0; msrc[u] = 0; mptr[u] = 0; mcnt[u] = 0; mdata[u] = '0;
    end
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    test_reset();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_burst();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
